// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM word port: widths, FSM states, half-op codes.
// Imported by the interface, the decoder and the top.
package sdram_pkg;

  localparam int HADDR_WIDTH_DEF = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GATE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_MERGE = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_RESP  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GATE  = ST_GATE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_MERGE = ST_MERGE,
    S_NEXT  = ST_NEXT,
    S_RESP  = ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_SKIP = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2,
    OP_RMW  = 2'd3
  } op_e;

  function automatic logic [15:0] merge_half(
    input logic [15:0] i_w,
    input logic [15:0] i_rb,
    input logic [1:0]  i_be
  );
    merge_half = {i_be[1] ? i_w[15:8] : i_rb[15:8],
                  i_be[0] ? i_w[7:0]  : i_rb[7:0]};
  endfunction

endpackage

// File: rtl/sdram_word_port_if.sv
// Host word bus: valid/ready request (we, addr, wdata, be) and 1-cycle response.
// master = host side, slave = sdram_word_port.
interface sdram_word_port_if
  import sdram_pkg::*;
#(
  parameter int WADDR_WIDTH = HADDR_WIDTH_DEF - 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [WADDR_WIDTH-1:0] req_addr;
  logic [31:0]            req_wdata;
  logic [3:0]             req_be;
  logic                   resp_valid;
  logic [31:0]            resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sdram_half_op_decode.sv
// Maps (we, byte-enable pair) of one halfword to the access plan for it.
// Ports: i_we, i_be[1:0] -> o_op (SKIP/RD/WR/RMW).
module sdram_half_op_decode
  import sdram_pkg::*;
(
  input  logic       i_we,
  input  logic [1:0] i_be,
  output op_e        o_op
);

  always_comb begin
    o_op = OP_SKIP;
    unique case (1'b1)
      !i_we:                   o_op = OP_RD;
      i_we && (i_be == 2'b11): o_op = OP_WR;
      i_we && (i_be == 2'b00): o_op = OP_SKIP;
      i_we && (^i_be):         o_op = OP_RMW;
    endcase
  end

endmodule

// File: rtl/sdram_word_port.sv
// 32-bit word port in front of sdram_controller: splits each request into
// low/high 16-bit accesses (RMW for partial halves). Ports: clk, rst_n, bus
// (host slave), sd_* controller side (addr, wr_data, enables, rd_data/ready, busy).
module sdram_word_port
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF,
  parameter int WADDR_WIDTH = HADDR_WIDTH - 1
)(
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_word_port_if.slave       bus,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [15:0]            sd_wr_data,
  output logic                   sd_rd_enable,
  output logic                   sd_wr_enable,
  input  logic [15:0]            sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_busy
);

  state_e                 r_state;
  state_e                 w_next;
  logic                   r_half;
  logic                   r_phase;
  logic                   r_we;
  logic [WADDR_WIDTH-1:0] r_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_be;
  logic [15:0]            r_lo;
  logic [15:0]            r_hi;
  logic [HADDR_WIDTH-1:0] r_sd_addr;
  logic [15:0]            r_sd_wdata;
  logic                   r_rd_en;
  logic                   r_wr_en;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic [31:0]            r_resp_rdata;

  logic                   w_we;
  logic [3:0]             w_be;
  op_e                    w_op0;
  op_e                    w_op1;
  op_e                    w_op;
  logic                   w_accept;
  logic                   w_do_rd;
  logic [15:0]            w_slot;
  logic [15:0]            w_whalf;
  logic [1:0]             w_bepair;

  // Decode from the live request while idle so the first move is known.
  assign w_we = (r_state == S_IDLE) ? bus.req_we : r_we;
  assign w_be = (r_state == S_IDLE) ? bus.req_be : r_be;

  sdram_half_op_decode u_dec_lo (
    .i_we (w_we),
    .i_be (w_be[1:0]),
    .o_op (w_op0)
  );

  sdram_half_op_decode u_dec_hi (
    .i_we (w_we),
    .i_be (w_be[3:2]),
    .o_op (w_op1)
  );

  assign w_op     = r_half ? w_op1 : w_op0;
  assign w_accept = bus.req_valid && r_req_ready;
  // RMW reads during phase 0, writes the merged half in phase 1.
  assign w_do_rd  = (w_op == OP_RD) || ((w_op == OP_RMW) && !r_phase);
  assign w_slot   = r_half ? r_hi : r_lo;
  assign w_whalf  = r_half ? r_wdata[31:16] : r_wdata[15:0];
  assign w_bepair = r_half ? r_be[3:2] : r_be[1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = (w_op0 == OP_SKIP) ? S_NEXT : S_GATE;
      S_GATE:
        if (!sd_busy) w_next = S_ISSUE;
      S_ISSUE:
        if (sd_busy) w_next = S_WAIT;
      S_WAIT:
        if (w_do_rd) begin
          if (sd_rd_ready)
            w_next = (w_op == OP_RMW) ? S_MERGE : S_NEXT;
        end else if (!sd_busy) begin
          w_next = S_NEXT;
        end
      S_MERGE:
        w_next = S_GATE;
      S_NEXT:
        if (r_half || (w_op1 == OP_SKIP)) w_next = S_RESP;
        else w_next = S_GATE;
      S_RESP:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_half       <= 1'b0;
      r_phase      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_sd_addr    <= '0;
      r_sd_wdata   <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next;
      r_req_ready  <= (w_next == S_IDLE);
      r_resp_valid <= (w_next == S_RESP);
      r_rd_en      <= (w_next == S_ISSUE) && w_do_rd;
      r_wr_en      <= (w_next == S_ISSUE) && !w_do_rd;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
        r_half  <= 1'b0;
        r_phase <= 1'b0;
      end
      if ((r_state == S_GATE) && (w_next == S_ISSUE)) begin
        r_sd_addr <= {r_addr, r_half};
        if (w_op == OP_WR) r_sd_wdata <= w_whalf;
      end
      if ((r_state == S_WAIT) && w_do_rd && sd_rd_ready) begin
        if (r_half) r_hi <= sd_rd_data;
        else        r_lo <= sd_rd_data;
      end
      if (r_state == S_MERGE) begin
        r_sd_wdata <= merge_half(w_whalf, w_slot, w_bepair);
        r_phase    <= 1'b1;
      end
      if (r_state == S_NEXT) begin
        r_half  <= 1'b1;
        r_phase <= 1'b0;
      end
      if ((w_next == S_RESP) && !r_we)
        r_resp_rdata <= {r_hi, r_lo};
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign sd_rd_addr     = r_sd_addr;
  assign sd_wr_addr     = r_sd_addr;
  assign sd_wr_data     = r_sd_wdata;
  assign sd_rd_enable   = r_rd_en;
  assign sd_wr_enable   = r_wr_en;

endmodule

// File: tb/tb_sdram_word_port.sv
// Bench for sdram_word_port: behavioural controller model (registered busy,
// init/refresh hold), table of word requests, multi-cycle corner sequences.
module tb_sdram_word_port;
  import sdram_pkg::*;

  localparam int HW = 24;
  localparam int WW = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_word_port_if #(.WADDR_WIDTH(WW)) bus ();

  logic [HW-1:0] sd_rd_addr;
  logic [HW-1:0] sd_wr_addr;
  logic [15:0]   sd_wr_data;
  logic          sd_rd_enable;
  logic          sd_wr_enable;
  logic [15:0]   sd_rd_data = 16'h0;
  logic          sd_rd_ready = 1'b0;
  logic          sd_busy = 1'b0;

  sdram_word_port #(.HADDR_WIDTH(HW), .WADDR_WIDTH(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sd_rd_addr   (sd_rd_addr),
    .sd_wr_addr   (sd_wr_addr),
    .sd_wr_data   (sd_wr_data),
    .sd_rd_enable (sd_rd_enable),
    .sd_wr_enable (sd_wr_enable),
    .sd_rd_data   (sd_rd_data),
    .sd_rd_ready  (sd_rd_ready),
    .sd_busy      (sd_busy)
  );

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        log_q[$];
  logic [15:0] mem [0:255];
  logic        m_st = 1'b0;
  logic        m_isrd = 1'b0;
  logic [23:0] m_addr = 24'h0;
  int          m_cnt = 0;
  logic        hold = 1'b0;
  int          resp_cnt = 0;
  int          both_cnt = 0;

  // Controller model: accepts an enable when idle, busy follows its state by one cycle.
  always @(posedge clk) begin
    sd_busy     <= m_st;
    sd_rd_ready <= 1'b0;
    if (!m_st) begin
      if (!hold && (sd_rd_enable || sd_wr_enable)) begin
        m_st   <= 1'b1;
        m_cnt  <= 3;
        m_isrd <= sd_rd_enable;
        m_addr <= sd_rd_addr;
        log_q.push_back({sd_wr_enable, sd_rd_addr, sd_wr_data});
        if (sd_wr_enable) mem[sd_wr_addr[7:0]] <= sd_wr_data;
      end
    end else if (m_cnt == 0) begin
      m_st <= 1'b0;
      if (m_isrd) begin
        sd_rd_ready <= 1'b1;
        sd_rd_data  <= mem[m_addr[7:0]];
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
  always @(negedge clk) if (sd_rd_enable && sd_wr_enable) both_cnt <= both_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_acc(input string nm, input int idx, input logic we,
                         input logic [23:0] a, input logic [15:0] d);
    acc_t e;
    e = (idx < log_q.size()) ? log_q[idx] : '0;
    chk({nm, "_we"}, 64'(e.we), 64'(we));
    chk({nm, "_addr"}, 64'(e.addr), 64'(a));
    if (we) chk({nm, "_data"}, 64'(e.data), 64'(d));
  endtask

  task automatic do_req(input logic we, input logic [22:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    bit got;
    lat = 0;
    rd  = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", 64'(got), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) begin
        got = 1'b1;
        lat = k + 1;
        rd  = bus.resp_rdata;
        break;
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1 chk("resp_pulse", 64'(bus.resp_valid), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          nacc;
    logic [31:0] rdata;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t        vt[9];
  int          start[9];
  int          lat;
  logic [31:0] rd;
  logic [31:0] prev;
  int          n0;
  int          held;
  int          r0;
  bit          got;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    vt[0] = '{1'b1, 23'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0,        16'hBEEF, 16'hDEAD};
    vt[1] = '{1'b0, 23'h10, 32'h0,        4'h0, 2, 32'hDEADBEEF, 16'hBEEF, 16'hDEAD};
    vt[2] = '{1'b1, 23'h10, 32'h00000012, 4'h1, 2, 32'h0,        16'hBE12, 16'hDEAD};
    vt[3] = '{1'b1, 23'h10, 32'h55667788, 4'h0, 0, 32'h0,        16'hBE12, 16'hDEAD};
    vt[4] = '{1'b1, 23'h11, 32'hA5A53C3C, 4'hC, 1, 32'h0,        16'h0000, 16'hA5A5};
    vt[5] = '{1'b1, 23'h11, 32'h77665544, 4'hA, 4, 32'h0,        16'h5500, 16'h77A5};
    vt[6] = '{1'b0, 23'h11, 32'h0,        4'hF, 2, 32'h77A55500, 16'h5500, 16'h77A5};
    vt[7] = '{1'b1, 23'h12, 32'h11223344, 4'h3, 1, 32'h0,        16'h3344, 16'h0000};
    vt[8] = '{1'b0, 23'h10, 32'h0,        4'h0, 2, 32'hDEADBE12, 16'hBE12, 16'hDEAD};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_rd_en", 64'(sd_rd_enable), 64'd0);
    chk("rst_wr_en", 64'(sd_wr_enable), 64'd0);
    chk("rst_addr", 64'(sd_rd_addr), 64'd0);
    chk("rst_wdata", 64'(sd_wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

    prev = 32'h0;
    for (int i = 0; i < 9; i++) begin
      start[i] = log_q.size();
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, lat, rd);
      chk($sformatf("v%0d_nacc", i), 64'(log_q.size() - start[i]), 64'(vt[i].nacc));
      if (!vt[i].we) prev = vt[i].rdata;
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(prev));
      chk($sformatf("v%0d_mem_lo", i), 64'(mem[{vt[i].addr[6:0], 1'b0}]), 64'(vt[i].lo));
      chk($sformatf("v%0d_mem_hi", i), 64'(mem[{vt[i].addr[6:0], 1'b1}]), 64'(vt[i].hi));
    end

    chk_acc("t1_lo", start[0], 1'b1, 24'h20, 16'hBEEF);
    chk_acc("t1_hi", start[0] + 1, 1'b1, 24'h21, 16'hDEAD);
    chk_acc("t2_lo", start[1], 1'b0, 24'h20, 16'h0);
    chk_acc("t2_hi", start[1] + 1, 1'b0, 24'h21, 16'h0);
    chk_acc("t3_rd", start[2], 1'b0, 24'h20, 16'h0);
    chk_acc("t3_wr", start[2] + 1, 1'b1, 24'h20, 16'hBE12);
    chk_acc("v5_wr_lo", start[5] + 1, 1'b1, 24'h22, 16'h5500);
    chk_acc("v5_wr_hi", start[5] + 3, 1'b1, 24'h23, 16'h77A5);

    n0 = log_q.size();
    do_req(1'b1, 23'h10, 32'hFFFFFFFF, 4'h0, lat, rd);
    chk("t4_latency", 64'(lat), 64'd2);
    chk("t4_nacc", 64'(log_q.size() - n0), 64'd0);

    n0   = log_q.size();
    held = 0;
    hold = 1'b1;
    fork
      do_req(1'b0, 23'h10, 32'h0, 4'hF, lat, rd);
      begin
        for (int i = 0; i < 50 && !sd_rd_enable; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (sd_rd_enable && !sd_busy) held++;
        end
        hold = 1'b0;
      end
    join
    chk("t5_held", 64'(held), 64'd20);
    chk("t5_nacc", 64'(log_q.size() - n0), 64'd2);
    chk("t5_rdata", 64'(rd), 64'hDEADBE12);
    chk_acc("t5_lo", n0, 1'b0, 24'h20, 16'h0);
    chk_acc("t5_hi", n0 + 1, 1'b0, 24'h21, 16'h0);

    n0 = log_q.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 23'h30;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_be    = 4'hF;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sd_busy && !sd_wr_enable && (log_q.size() > n0)) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_reach_wait", 64'(got), 64'd1);
    r0    = resp_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t6_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("t6_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("t6_rd_en", 64'(sd_rd_enable), 64'd0);
    chk("t6_wr_en", 64'(sd_wr_enable), 64'd0);
    chk("t6_addr", 64'(sd_wr_addr), 64'd0);
    chk("t6_wdata", 64'(sd_wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("t6_no_resp", 64'(resp_cnt), 64'(r0));
    chk("t6_one_access", 64'(log_q.size() - n0), 64'd1);

    n0 = log_q.size();
    do_req(1'b0, 23'h30, 32'h0, 4'hF, lat, rd);
    chk("t6_next_nacc", 64'(log_q.size() - n0), 64'd2);
    chk("t6_next_rdata", 64'(rd), 64'h0000F00D);
    chk("t6_hi_untouched", 64'(mem[8'h61]), 64'd0);

    chk("never_both_enables", 64'(both_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
